// File: rtl/regfile_param.sv
// regfile_param: parameterised multi-port register file
// byte-lane writes, optional zero register, optional write-to-read bypass
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int NBYTE   = WIDTH / 8
) (
  input  logic                       Clk,
  input  logic                       ResetN,
  input  logic [NWRITE-1:0]          RegWrite,
  input  logic [NWRITE*ADDR_W-1:0]   WriteRegister,
  input  logic [NWRITE*WIDTH-1:0]    WriteData,
  input  logic [NWRITE*NBYTE-1:0]    WriteByteEn,
  input  logic [NREAD*ADDR_W-1:0]    ReadRegister,
  output logic [NREAD*WIDTH-1:0]     ReadData,
  input  logic                       Clear,
  output logic                       WriteConflict
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              conflict_q;
  logic              armed;

  logic [ADDR_W-1:0] waddr [NWRITE];
  logic [WIDTH-1:0]  wdata [NWRITE];
  logic [NBYTE-1:0]  wbe   [NWRITE];
  logic [NWRITE-1:0] wen;
  logic              hit;

  logic [ADDR_W-1:0] raddr [NREAD];
  logic [WIDTH-1:0]  rval  [NREAD];

  // Unpack write ports; a port is live only once out of reset recovery,
  // outside a clear, and not aimed at a hardwired zero register.
  always_comb begin
    wen = '0;
    for (int p = 0; p < NWRITE; p++) begin
      waddr[p] = WriteRegister[p*ADDR_W +: ADDR_W];
      wdata[p] = WriteData[p*WIDTH +: WIDTH];
      wbe[p]   = WriteByteEn[p*NBYTE +: NBYTE];
      wen[p]   = RegWrite[p] & armed & ~Clear;
      if (ZERO_REG != 0 && waddr[p] == '0)
        wen[p] = 1'b0;
    end
  end

  // Two live ports on the same address, regardless of byte enables.
  always_comb begin
    hit = 1'b0;
    for (int p = 0; p < NWRITE; p++) begin
      for (int q = p + 1; q < NWRITE; q++) begin
        if (wen[p] && wen[q] && waddr[p] == waddr[q])
          hit = 1'b1;
      end
    end
  end

  // Storage update; later ports overwrite earlier ones lane by lane.
  // The first edge after reset release only arms the write path.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      conflict_q <= 1'b0;
      armed      <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (Clear) begin
        for (int i = 0; i < DEPTH; i++)
          mem[i] <= '0;
        conflict_q <= 1'b0;
      end else begin
        if (hit)
          conflict_q <= 1'b1;
        for (int p = 0; p < NWRITE; p++) begin
          for (int b = 0; b < NBYTE; b++) begin
            if (wen[p] && wbe[p][b])
              mem[waddr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

  assign WriteConflict = conflict_q;

  // Combinational reads with optional forwarding of this cycle's writes.
  always_comb begin
    ReadData = '0;
    for (int r = 0; r < NREAD; r++) begin
      raddr[r] = ReadRegister[r*ADDR_W +: ADDR_W];
      rval[r]  = mem[raddr[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWRITE; p++) begin
          for (int b = 0; b < NBYTE; b++) begin
            if (wen[p] && wbe[p][b] && waddr[p] == raddr[r])
              rval[r][b*8 +: 8] = wdata[p][b*8 +: 8];
          end
        end
        if (Clear)
          rval[r] = '0;
      end
      if (ZERO_REG != 0 && raddr[r] == '0)
        rval[r] = '0;
      if (!ResetN)
        rval[r] = '0;
      ReadData[r*WIDTH +: WIDTH] = rval[r];
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: two configurations on shared stimulus
// (zero-reg/no-bypass and plain-r0/bypass) against an array model
module tb_regfile_param;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [1:0]  RegWrite;
  logic [9:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [7:0]  WriteByteEn;
  logic [9:0]  ReadRegister;
  logic        Clear;
  logic [63:0] rda, rdb;
  logic        cfa, cfb;

  always #5 Clk = ~Clk;

  regfile_param dut_a (
    .Clk(Clk), .ResetN(ResetN), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .WriteByteEn(WriteByteEn), .ReadRegister(ReadRegister),
    .ReadData(rda), .Clear(Clear), .WriteConflict(cfa)
  );

  regfile_param #(.ZERO_REG(0), .BYPASS(1)) dut_b (
    .Clk(Clk), .ResetN(ResetN), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .WriteByteEn(WriteByteEn), .ReadRegister(ReadRegister),
    .ReadData(rdb), .Clear(Clear), .WriteConflict(cfb)
  );

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [31:0] na [32];
  logic [31:0] nb [32];
  logic        ca, cb, nca, ncb, armed;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  function automatic logic [4:0] wa(input int p);
    return WriteRegister[p*5 +: 5];
  endfunction

  function automatic logic [4:0] ra(input int r);
    return ReadRegister[r*5 +: 5];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    ca = 1'b0;
    cb = 1'b0;
    armed = 1'b0;
  endtask

  // Post-edge state from current inputs: later port wins per byte.
  task automatic model_next();
    na = ma;
    nb = mb;
    nca = ca;
    ncb = cb;
    if (!ResetN || Clear) begin
      for (int i = 0; i < 32; i++) begin
        na[i] = '0;
        nb[i] = '0;
      end
      nca = 1'b0;
      ncb = 1'b0;
    end else if (armed) begin
      for (int p = 0; p < 2; p++) begin
        if (RegWrite[p]) begin
          for (int b = 0; b < 4; b++) begin
            if (WriteByteEn[p*4+b]) begin
              if (wa(p) != 0)
                na[wa(p)][b*8 +: 8] = WriteData[p*32+b*8 +: 8];
              nb[wa(p)][b*8 +: 8] = WriteData[p*32+b*8 +: 8];
            end
          end
        end
      end
      if (RegWrite == 2'b11 && wa(0) == wa(1)) begin
        ncb = 1'b1;
        if (wa(0) != 0) nca = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_a(input int r);
    if (!ResetN || ra(r) == 0) return '0;
    return ma[ra(r)];
  endfunction

  function automatic logic [31:0] exp_b(input int r);
    if (!ResetN || Clear) return '0;
    return armed ? nb[ra(r)] : mb[ra(r)];
  endfunction

  task automatic check_reads();
    for (int r = 0; r < 2; r++) begin
      check($sformatf("rdA%0d", r), rda[r*32 +: 32], exp_a(r));
      check($sformatf("rdB%0d", r), rdb[r*32 +: 32], exp_b(r));
    end
  endtask

  // One cycle: pre-edge read checks, edge, flag checks, back at negedge.
  task automatic step(input bit rel = 1'b0);
    model_next();
    #1;
    check_reads();
    if (rel) begin
      #3;
      ResetN = 1'b1;
      model_next();
    end
    @(posedge Clk);
    #1;
    ma = na;
    mb = nb;
    ca = nca;
    cb = ncb;
    armed = ResetN;
    check("cfA", cfa, ca);
    check("cfB", cfb, cb);
    @(negedge Clk);
  endtask

  task automatic drive(input logic [1:0] we,
                       input logic [4:0] w0, input logic [4:0] w1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] b0, input logic [3:0] b1,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic clr);
    RegWrite      = we;
    WriteRegister = {w1, w0};
    WriteData     = {d1, d0};
    WriteByteEn   = {b1, b0};
    ReadRegister  = {r1, r0};
    Clear         = clr;
  endtask

  task automatic probe(input logic [4:0] r0, input logic [4:0] r1);
    drive(2'b00, 5'd0, 5'd0, '0, '0, 4'h0, 4'h0, r0, r1, 1'b0);
    #1;
  endtask

  initial begin
    model_reset();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 4'h0, 4'h0, 5'd0, 5'd0, 1'b0);
    @(negedge Clk);
    // write presented on the release edge must be dropped
    drive(2'b01, 5'd4, 5'd0, 32'h55, '0, 4'hF, 4'h0, 5'd4, 5'd3, 1'b0);
    step(1'b1);
    probe(5'd4, 5'd3);
    check("rel_edge_a", rda[31:0], 32'h0);
    check("rel_edge_b", rdb[31:0], 32'h0);
    check("r3_zero", rda[63:32], 32'h0);

    drive(2'b01, 5'd2, 5'd0, 32'd42, '0, 4'hF, 4'h0, 5'd2, 5'd2, 1'b0);
    step();
    probe(5'd2, 5'd2);
    check("r2_p0", rda[31:0], 32'd42);
    check("r2_p1", rda[63:32], 32'd42);
    probe(5'd3, 5'd3);
    check("r3_after", rda[31:0], 32'h0);

    drive(2'b11, 5'd5, 5'd5, 32'h11111111, 32'h22220000,
          4'hF, 4'b1100, 5'd5, 5'd5, 1'b0);
    step();
    probe(5'd5, 5'd5);
    check("merge_a", rda[31:0], 32'h22221111);
    check("merge_b", rdb[31:0], 32'h22221111);
    check("conf_a", cfa, 1'b1);
    check("conf_b", cfb, 1'b1);
    step();
    step();
    check("sticky", cfa, 1'b1);
    drive(2'b00, 5'd0, 5'd0, '0, '0, 4'h0, 4'h0, 5'd5, 5'd2, 1'b1);
    step();
    probe(5'd5, 5'd2);
    check("clr_r5", rda[31:0], 32'h0);
    check("clr_r2", rdb[63:32], 32'h0);
    check("clr_cf", cfa, 1'b0);

    drive(2'b01, 5'd0, 5'd0, 32'd15, '0, 4'hF, 4'h0, 5'd0, 5'd0, 1'b0);
    step();
    probe(5'd0, 5'd0);
    check("r0_zero", rda[31:0], 32'h0);
    check("r0_plain", rdb[31:0], 32'd15);
    check("r0_nocf", cfa, 1'b0);
    drive(2'b11, 5'd0, 5'd0, 32'd1, 32'd2, 4'hF, 4'hF, 5'd0, 5'd0, 1'b0);
    step();
    check("r0_cf_a", cfa, 1'b0);
    check("r0_cf_b", cfb, 1'b1);
    probe(5'd0, 5'd0);
    check("r0_hiport", rdb[31:0], 32'd2);
    drive(2'b00, 5'd0, 5'd0, '0, '0, 4'h0, 4'h0, 5'd0, 5'd0, 1'b1);
    step();

    drive(2'b00, 5'd2, 5'd0, 32'd42, '0, 4'hF, 4'h0, 5'd2, 5'd2, 1'b0);
    step();
    probe(5'd2, 5'd2);
    check("we_off", rda[31:0], 32'h0);
    drive(2'b01, 5'd2, 5'd0, 32'hAABBCCDD, '0, 4'b0001, 4'h0,
          5'd2, 5'd2, 1'b0);
    step();
    probe(5'd2, 5'd2);
    check("lane0", rda[31:0], 32'h000000DD);

    drive(2'b11, 5'd7, 5'd7, 32'd1, 32'd2, 4'h0, 4'h0, 5'd7, 5'd7, 1'b0);
    step();
    check("nobe_cf", cfa, 1'b1);
    probe(5'd7, 5'd7);
    check("nobe_data", rda[31:0], 32'h0);
    drive(2'b00, 5'd0, 5'd0, '0, '0, 4'h0, 4'h0, 5'd0, 5'd0, 1'b1);
    step();

    drive(2'b01, 5'd9, 5'd0, 32'd7, '0, 4'hF, 4'h0, 5'd9, 5'd9, 1'b0);
    #1;
    check("byp_b", rdb[31:0], 32'd7);
    check("nobyp_a", rda[31:0], 32'h0);
    step();
    probe(5'd9, 5'd9);
    check("after_a", rda[31:0], 32'd7);

    drive(2'b01, 5'd6, 5'd0, 32'd15, '0, 4'hF, 4'h0, 5'd6, 5'd6, 1'b0);
    step();
    probe(5'd6, 5'd6);
    check("r6_set", rda[31:0], 32'd15);
    drive(2'b01, 5'd6, 5'd0, 32'd99, '0, 4'hF, 4'h0, 5'd6, 5'd6, 1'b1);
    #1;
    ResetN = 1'b0;
    model_reset();
    #1;
    check("async_a", rda[31:0], 32'h0);
    check("async_b", rdb[31:0], 32'h0);
    check("async_cf", cfb, 1'b0);
    step();
    drive(2'b01, 5'd6, 5'd0, 32'd99, '0, 4'hF, 4'h0, 5'd6, 5'd6, 1'b0);
    step(1'b1);
    probe(5'd6, 5'd6);
    check("rel_nowr", rda[31:0], 32'h0);
    drive(2'b01, 5'd6, 5'd0, 32'd99, '0, 4'hF, 4'h0, 5'd6, 5'd6, 1'b0);
    step();
    probe(5'd6, 5'd6);
    check("first_wr", rda[31:0], 32'd99);

    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
            5'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 24) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
